// File: rtl/display_driver.sv
// Four-digit multiplexed 7-segment driver: captures a 14-bit binary value, converts it to BCD
// with an iterative double-dabble, and scans the digits with leading-zero blanking.
module display_driver #(
    parameter int unsigned DIGIT_PERIOD = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic [6:0]  y,
    output logic [3:0]  Anode_Activate
);

    localparam logic [19:0] ScanLast = 20'(DIGIT_PERIOD - 1);

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    state_e      state_q, state_d;
    logic [13:0] shift_q, shift_d;
    logic [15:0] bcd_q, bcd_d, bcd_adj;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        ovf_q, ovf_d;
    logic [15:0] disp_q, disp_d;
    logic        disp_ovf_q, disp_ovf_d;
    logic [19:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  y_q, y_d;
    logic [3:0]  digit;
    logic        blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Conversion FSM and display register
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        disp_ovf_d = disp_ovf_q;
        bcd_adj    = bcd_q;
        for (int k = 0; k < 4; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    shift_d   = value;
                    bcd_d     = 16'd0;
                    bit_cnt_d = 4'd0;
                    ovf_d     = (value > 14'd9999);
                    state_d   = StConv;
                end
            end
            StConv: begin
                bcd_d     = (bcd_adj << 1) | {15'd0, shift_q[13]};
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd13) begin
                    // Last shift: commit the finished result in the same edge busy falls.
                    state_d    = StIdle;
                    disp_ovf_d = ovf_q;
                    disp_d     = ovf_q ? 16'd0 : bcd_d;
                end
            end
        endcase
    end

    // Free-running digit scan
    always_comb begin
        scan_cnt_d = scan_cnt_q + 20'd1;
        idx_d      = idx_q;
        if (scan_cnt_q == ScanLast) begin
            scan_cnt_d = 20'd0;
            idx_d      = idx_q + 2'd1;
        end
    end

    // Output registers are fed from next-state so y and the anode always match the
    // current index and display register.
    always_comb begin
        digit = disp_d[3:0];
        blank = 1'b0;
        unique case (idx_d)
            2'd0: begin digit = disp_d[3:0];   blank = 1'b0;                  end
            2'd1: begin digit = disp_d[7:4];   blank = (disp_d[15:4] == 12'd0); end
            2'd2: begin digit = disp_d[11:8];  blank = (disp_d[15:8] == 8'd0);  end
            2'd3: begin digit = disp_d[15:12]; blank = (disp_d[15:12] == 4'd0); end
        endcase
        an_d = ~(4'b0001 << idx_d);
        if (disp_ovf_d) begin
            y_d = 7'b0111111;
        end else if (blank) begin
            y_d = 7'b1111111;
        end else begin
            y_d = seg7(digit);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= StIdle;
            shift_q    <= 14'd0;
            bcd_q      <= 16'd0;
            bit_cnt_q  <= 4'd0;
            ovf_q      <= 1'b0;
            disp_q     <= 16'd0;
            disp_ovf_q <= 1'b0;
            scan_cnt_q <= 20'd0;
            idx_q      <= 2'd0;
            an_q       <= 4'b1110;
            y_q        <= 7'b1000000;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            disp_ovf_q <= disp_ovf_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            y_q        <= y_d;
        end
    end

    assign busy           = (state_q == StConv);
    assign y              = y_q;
    assign Anode_Activate = an_q;

endmodule

// File: tb/tb_display_driver.sv
// Bench for display_driver: a decimal-arithmetic reference model checked every cycle, a table of
// value/segment vectors, hand-written corner sequences and randomized loads/resets.
module tb_display_driver;

    localparam int unsigned DP = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        load = 1'b0;
    logic [13:0] value = 14'd0;
    logic        busy;
    logic [6:0]  y;
    logic [3:0]  an;

    display_driver #(.DIGIT_PERIOD(DP)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .value          (value),
        .load           (load),
        .busy           (busy),
        .y              (y),
        .Anode_Activate (an)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: displayed number, overflow flag, cycles of busy left, cycles since reset
    int m_num = 0;
    int m_pend = 0;
    int m_busy_left = 0;
    int m_scan = 0;
    bit m_ovf = 1'b0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    typedef struct {
        logic [13:0] val;
        logic [27:0] segs; // {thousands, hundreds, tens, units}
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic logic [6:0] model_y(input int idx);
        int p;
        int d;
        p = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
        if (m_ovf) return 7'b0111111;
        if (idx > 0 && m_num < p) return 7'b1111111;
        d = (m_num / p) % 10;
        return seg_tab[d];
    endfunction

    // One clock: advance the model with the inputs present at the edge, then compare outputs.
    task automatic cyc();
        int exp_idx;
        logic [3:0] exp_an;
        @(posedge clk);
        if (rstn) begin
            m_num = 0;
            m_ovf = 1'b0;
            m_busy_left = 0;
            m_scan = 0;
        end else begin
            m_scan++;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    if (m_pend > 9999) begin
                        m_ovf = 1'b1;
                    end else begin
                        m_num = m_pend;
                        m_ovf = 1'b0;
                    end
                end
            end else if (load) begin
                m_pend = int'(value);
                m_busy_left = 14;
            end
        end
        #1;
        exp_idx = (m_scan / int'(DP)) % 4;
        exp_an  = ~(4'b0001 << exp_idx);
        check("busy", 32'(busy), 32'(m_busy_left > 0));
        check("anode", 32'(an), 32'(exp_an));
        check("y", 32'(y), 32'(model_y(exp_idx)));
    endtask

    task automatic load_val(input logic [13:0] v);
        value = v;
        load  = 1'b1;
        cyc();
        load  = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            cyc();
            k++;
        end
        if (busy) timeout("wait_idle");
    endtask

    task automatic scan_digits(input string tag, input logic [27:0] segs);
        logic [3:0] want;
        for (int i = 0; i < 4; i++) begin
            int k;
            want = ~(4'b0001 << i);
            k = 0;
            while (an !== want && k < 20) begin
                cyc();
                k++;
            end
            if (an !== want) timeout({tag, "_anode"});
            else check({tag, "_digit"}, 32'(y), 32'(segs[7*i +: 7]));
        end
    endtask

    initial begin
        int bc;
        int seen9;

        vecs[0] = '{14'd1234,  {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1] = '{14'd7,     {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}};
        vecs[2] = '{14'd9999,  {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}};
        vecs[3] = '{14'd12000, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
        vecs[4] = '{14'd0,     {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
        vecs[5] = '{14'd10,    {7'b1111111, 7'b1111111, 7'b1111001, 7'b1000000}};
        vecs[6] = '{14'd1000,  {7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000}};
        vecs[7] = '{14'd16383, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
        vecs[8] = '{14'd5678,  {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}};
        vecs[9] = '{14'd305,   {7'b1111111, 7'b0110000, 7'b1000000, 7'b0010010}};

        // Reset for three cycles, then watch one full scan of a blank display
        rstn = 1'b1;
        repeat (3) cyc();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_anode", 32'(an), 32'(4'b1110));
        check("rst_y", 32'(y), 32'(7'b1000000));
        rstn = 1'b0;
        repeat (16) cyc();

        // Busy lasts exactly 14 cycles
        load_val(14'd1234);
        bc = 0;
        while (busy && bc < 40) begin
            bc++;
            cyc();
        end
        check("busy_len", 32'(bc), 32'd14);
        scan_digits("d1234", vecs[0].segs);

        for (int v = 0; v < 10; v++) begin
            load_val(vecs[v].val);
            wait_idle();
            scan_digits($sformatf("vec%0d", v), vecs[v].segs);
        end

        // Load during busy cycle 5 is ignored; a later load is accepted
        load_val(14'd1234);
        repeat (4) cyc();
        value = 14'd5678;
        load  = 1'b1;
        cyc();
        load  = 1'b0;
        wait_idle();
        scan_digits("ign1234", vecs[0].segs);
        load_val(14'd5678);
        wait_idle();
        scan_digits("acc5678", vecs[8].segs);

        // Reset at busy cycle 7 aborts the conversion and clears the display
        load_val(14'd1234);
        wait_idle();
        load_val(14'd9999);
        repeat (6) cyc();
        rstn = 1'b1;
        cyc();
        rstn = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_anode", 32'(an), 32'(4'b1110));
        check("abort_y", 32'(y), 32'(7'b1000000));
        seen9 = 0;
        repeat (40) begin
            cyc();
            if (y == 7'b0010000) seen9++;
        end
        check("abort_no9999", 32'(seen9), 32'd0);
        scan_digits("abort_zero", vecs[4].segs);

        // Reset wins over a simultaneous load
        rstn  = 1'b1;
        value = 14'd1234;
        load  = 1'b1;
        cyc();
        rstn  = 1'b0;
        load  = 1'b0;
        cyc();
        check("rst_load_busy", 32'(busy), 32'd0);
        repeat (20) cyc();

        // Randomized loads (some overlapping busy, some overflowing) and occasional resets
        for (int it = 0; it < 300; it++) begin
            repeat ($urandom_range(0, 20)) cyc();
            if ($urandom_range(0, 19) == 0) begin
                rstn = 1'b1;
                cyc();
                rstn = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) value = 14'($urandom_range(10000, 16383));
                else value = 14'($urandom_range(0, 9999));
                load = 1'b1;
                cyc();
                load = 1'b0;
            end
        end
        repeat (40) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_driver.md
DISPLAY_DRIVER -- requirements
Module: display_driver

Interface
REQ-001 Parameter: DIGIT_PERIOD, default 100000, clock cycles each digit is driven before the scan advances (legal range 2..2^20).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rstn  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 value  input  14  unsigned binary result from the calculator core, captured only on load.
REQ-005 load  input  1  single-cycle strobe requesting display of value.
REQ-006 busy  output  1  high while a binary-to-BCD conversion is in progress.
REQ-007 y  output  7  segment drive, active-low, bit order y[6:0] = g,f,e,d,c,b,a.
REQ-008 Anode_Activate  output  4  digit enable, active-low one-hot; bit 0 = units, bit 3 = thousands.

Function
REQ-009 FSM states: IDLE, CONV; IDLE -> CONV on load=1 with busy=0; CONV -> IDLE after exactly 14 shift cycles.
REQ-010 load accepted in IDLE: value captured that edge; busy=1 from the next cycle for exactly 14 cycles.
REQ-011 load asserted while busy=1 is ignored; no queuing, no effect on the conversion in progress.
REQ-012 Conversion: iterative shift-add-3 (double dabble), one bit per cycle, MSB first, into a 16-bit BCD working register.
REQ-013 Captured value > 9999: overflow flag set; BCD result discarded at completion.
REQ-014 Display register (four BCD digits + overflow flag) updated atomically on the edge where busy falls; old contents shown until then.
REQ-015 Scan counter counts 0..DIGIT_PERIOD-1 and wraps; on wrap the digit index advances 0->1->2->3->0.
REQ-016 Scan counter and digit index run continuously, independent of load/busy.
REQ-017 Anode_Activate = ~(4'b0001 << index); exactly one bit low at all times after reset.
REQ-018 Segment codes (y): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Leading-zero blanking: a non-units digit is blank (y=1111111) when it and all higher digits are 0; the units digit is never blanked.
REQ-020 Overflow flag set in display register: every digit shows y=0111111 (segment g only).
REQ-021 y and Anode_Activate are registered; y always corresponds to the digit selected by Anode_Activate in the same cycle.

Reset
REQ-022 rstn=1 clears: FSM to IDLE, busy=0, working register 0, display digits 0, overflow flag 0, scan counter 0, index 0.
REQ-023 Outputs during and directly after reset: Anode_Activate=1110, y=1000000 (units "0", higher digits blank).
REQ-024 rstn asserted mid-conversion aborts it; the display register is cleared, not updated with partial data.
REQ-025 rstn takes priority over a simultaneous load; that load is lost.

Verification (DIGIT_PERIOD=4)
REQ-026 Reset 3 cycles -> busy=0, Anode_Activate=1110, y=1000000; scan visits 1101, 1011, 0111 with y=1111111, 4 cycles each.
REQ-027 load with value=1234 -> busy high exactly 14 cycles; then units..thousands show 0011001, 0110000, 0100100, 1111001.
REQ-028 load value=7 -> units y=1111000; tens, hundreds, thousands y=1111111.
REQ-029 load value=9999 -> all digits 0010000; then load value=12000 -> all digits 0111111.
REQ-030 load 1234; load 5678 at busy cycle 5 -> ignored, display shows 1234; load 5678 after busy falls -> 0010010-style digits 8,7,6,5 appear.
REQ-031 Display 1234 shown, load 9999, rstn pulsed at busy cycle 7 -> busy=0 next cycle, display reads "0" (REQ-023); 9999 never appears.
